// File: rtl/sqrt_iter.sv
// Handshaked digit-recurrence (non-restoring) square root with sideband tag.
// Retires BPC root bits per CALC cycle; the final correction and rounding happen in the last cycle.
module sqrt_iter #(
    parameter int IN_W     = 31,
    parameter int IN_FRAC  = 24,
    parameter int OUT_W    = 17,
    parameter int OUT_FRAC = 13,
    parameter int BPC      = 1,
    parameter int ROUND    = 0,
    parameter int TAG_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int N    = OUT_W / BPC;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int RADW = 2 * OUT_W;
    localparam int SH   = 2 * OUT_FRAC - IN_FRAC;
    // Partial remainder needs two headroom bits beyond the root plus a sign bit.
    localparam int RW   = OUT_W + 3;

    if ((OUT_W % BPC) != 0) begin : g_chk_bpc
        $error("sqrt_iter: OUT_W must be a multiple of BPC");
    end
    if (2 * OUT_FRAC < IN_FRAC) begin : g_chk_frac
        $error("sqrt_iter: 2*OUT_FRAC must be >= IN_FRAC");
    end
    if (IN_W + 2 * OUT_FRAC - IN_FRAC > 2 * OUT_W) begin : g_chk_width
        $error("sqrt_iter: shifted radicand does not fit in 2*OUT_W bits");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RADW-1:0]  rad_q, rad_d;
    logic [OUT_W-1:0] root_q, root_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [RW-1:0]    chain_r;
    logic [OUT_W-1:0] chain_q;
    logic [RW-1:0]    rem_fix;
    logic             round_up;
    logic [OUT_W-1:0] result;

    always_comb begin : calc_chain
        logic [RW-1:0]    r;
        logic [RW-1:0]    r_sh;
        logic [OUT_W-1:0] q;
        r    = rem_q;
        q    = root_q;
        r_sh = '0;
        for (int i = 0; i < BPC; i++) begin
            r_sh = {r[RW-3:0], rad_q[RADW-1-2*i -: 2]};
            if (r[RW-1]) begin
                r = r_sh + {1'b0, q, 2'b11};
            end else begin
                r = r_sh - {1'b0, q, 2'b01};
            end
            q = {q[OUT_W-2:0], ~r[RW-1]};
        end
        chain_r = r;
        chain_q = q;
    end

    // A negative final remainder is restored to R - q^2 before the rounding test.
    always_comb begin
        rem_fix  = chain_r[RW-1] ? (chain_r + {2'b00, chain_q, 1'b1}) : chain_r;
        round_up = (ROUND != 0) && (rem_fix > {3'b000, chain_q});
        result   = chain_q;
        if (round_up && !(&chain_q)) begin
            result = chain_q + OUT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rad_d      = rad_q;
        root_d     = root_q;
        rem_d      = rem_q;
        tag_d      = tag_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    rad_d   = RADW'(in_data) << SH;
                    tag_d   = in_tag;
                    root_d  = '0;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rad_d  = rad_q << (2 * BPC);
                root_d = chain_q;
                rem_d  = chain_r;
                if (cnt_q == CW'(N - 1)) begin
                    out_data_d = result;
                    out_tag_d  = tag_q;
                    cnt_d      = '0;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // in_ready resets to 0 and rises on the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rad_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            tag_q       <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rad_q       <= rad_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            tag_q       <= tag_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Directed bench for sqrt_iter: four instances cover truncation, rounding,
// BPC=17 throughput and 16-bit output saturation.
module tb_sqrt_iter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instances A (ROUND=0) and B (ROUND=1) share their input side.
    logic        ab_in_valid = 1'b0;
    logic        ab_out_ready = 1'b0;
    logic [30:0] ab_in_data = '0;
    logic [1:0]  ab_in_tag = '0;
    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [16:0] a_out_data, b_out_data;
    logic [1:0]  a_out_tag, b_out_tag;

    logic        c_in_valid = 1'b0;
    logic        c_out_ready = 1'b0;
    logic [30:0] c_in_data = '0;
    logic [1:0]  c_in_tag = '0;
    logic        c_in_ready, c_out_valid;
    logic [16:0] c_out_data;
    logic [1:0]  c_out_tag;

    logic        d_in_valid = 1'b0;
    logic        d_out_ready = 1'b0;
    logic [31:0] d_in_data = '0;
    logic [1:0]  d_in_tag = '0;
    logic        d_in_ready, d_out_valid;
    logic [15:0] d_out_data;
    logic [1:0]  d_out_tag;

    sqrt_iter #(.ROUND(0), .BPC(1)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(ab_in_valid), .in_ready(a_in_ready), .in_data(ab_in_data), .in_tag(ab_in_tag),
        .out_valid(a_out_valid), .out_ready(ab_out_ready), .out_data(a_out_data), .out_tag(a_out_tag)
    );

    sqrt_iter #(.ROUND(1), .BPC(1)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(ab_in_valid), .in_ready(b_in_ready), .in_data(ab_in_data), .in_tag(ab_in_tag),
        .out_valid(b_out_valid), .out_ready(ab_out_ready), .out_data(b_out_data), .out_tag(b_out_tag)
    );

    sqrt_iter #(.ROUND(1), .BPC(17)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_tag(c_out_tag)
    );

    sqrt_iter #(.IN_W(32), .OUT_W(16), .OUT_FRAC(12), .ROUND(1), .BPC(1)) u_d (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_tag(d_in_tag),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .out_tag(d_out_tag)
    );

    function automatic longint unsigned isqrt(input longint unsigned r);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 64'd262143;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= r) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    task automatic ab_run(input string name, input logic [30:0] x, input logic [1:0] tag,
                          input logic [16:0] ea, input logic [16:0] eb, input int stall);
        int lat;
        int k;
        @(negedge clk);
        ab_in_valid = 1'b1;
        ab_in_data  = x;
        ab_in_tag   = tag;
        ab_out_ready = 1'b0;
        k = 0;
        while (!a_in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b required 1", name, a_in_ready);
        end
        @(negedge clk);
        ab_in_valid = 1'b0;
        ab_in_data  = ~x;
        ab_in_tag   = ~tag;
        lat = 0;
        while (!a_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 17) begin
            errors++;
            $display("FAIL %s latency: got %0d required 17", name, lat);
        end
        checks++;
        if (a_out_data !== ea || a_out_tag !== tag) begin
            errors++;
            $display("FAIL %s trunc: data=%0h tag=%0h required data=%0h tag=%0h", name, a_out_data, a_out_tag, ea, tag);
        end
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== eb || b_out_tag !== tag) begin
            errors++;
            $display("FAIL %s round: valid=%b data=%0h tag=%0h required 1 %0h %0h", name, b_out_valid, b_out_data, b_out_tag, eb, tag);
        end
        repeat (stall) @(negedge clk);
        ab_out_ready = 1'b1;
        @(negedge clk);
        ab_out_ready = 1'b0;
        checks++;
        if ({a_in_ready, a_out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL %s retire: in_ready=%b out_valid=%b required 1 0", name, a_in_ready, a_out_valid);
        end
        $display("txn %s in=%0h tag=%0d trunc=%0h round=%0h lat=%0d", name, x, tag, a_out_data, b_out_data, lat);
    endtask

    task automatic c_run(input string name, input logic [30:0] x, input logic [1:0] tag, input logic [16:0] e);
        int lat;
        @(negedge clk);
        c_in_valid = 1'b1;
        c_in_data  = x;
        c_in_tag   = tag;
        @(negedge clk);
        c_in_valid = 1'b0;
        lat = 0;
        while (!c_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 1 || c_out_data !== e || c_out_tag !== tag) begin
            errors++;
            $display("FAIL %s bpc17: lat=%0d data=%0h tag=%0h required 1 %0h %0h", name, lat, c_out_data, c_out_tag, e, tag);
        end
        c_out_ready = 1'b1;
        @(negedge clk);
        c_out_ready = 1'b0;
        $display("txn %s in=%0h out=%0h lat=%0d", name, x, c_out_data, lat);
    endtask

    task automatic d_run(input string name, input logic [31:0] x, input logic [15:0] e);
        int lat;
        @(negedge clk);
        d_in_valid = 1'b1;
        d_in_data  = x;
        d_in_tag   = 2'd2;
        @(negedge clk);
        d_in_valid = 1'b0;
        lat = 0;
        while (!d_out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 16 || d_out_data !== e || d_out_tag !== 2'd2) begin
            errors++;
            $display("FAIL %s sat16: lat=%0d data=%0h tag=%0h required 16 %0h 2", name, lat, d_out_data, d_out_tag, e);
        end
        d_out_ready = 1'b1;
        @(negedge clk);
        d_out_ready = 1'b0;
        $display("txn %s in=%0h out=%0h lat=%0d", name, x, d_out_data, lat);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_in_ready, a_out_valid, a_out_data, a_out_tag} !== 21'd0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b valid=%b data=%0h tag=%0h required all 0", a_in_ready, a_out_valid, a_out_data, a_out_tag);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: in_ready=%b required 0", a_in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({a_in_ready, c_in_ready, d_in_ready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready: a=%b c=%b d=%b required 1 1 1", a_in_ready, c_in_ready, d_in_ready);
        end
    endtask

    task automatic test_basic();
        ab_run("four",     31'h4000000, 2'd1, 17'h04000, 17'h04000, 0);
        ab_run("zero",     31'h0000000, 2'd2, 17'h00000, 17'h00000, 1);
        ab_run("one",      31'h1000000, 2'd3, 17'h02000, 17'h02000, 0);
        ab_run("lsb1",     31'h0000001, 2'd0, 17'h00002, 17'h00002, 0);
        ab_run("lsb2",     31'h0000002, 2'd1, 17'h00002, 17'h00003, 2);
        ab_run("lsb3",     31'h0000003, 2'd2, 17'h00003, 17'h00003, 0);
        ab_run("lsb5",     31'h0000005, 2'd3, 17'h00004, 17'h00004, 0);
        ab_run("lsb6",     31'h0000006, 2'd0, 17'h00004, 17'h00005, 0);
        ab_run("fullscale", 31'h7FFFFFFF, 2'd1, 17'd92681, 17'd92682, 0);
    endtask

    task automatic test_backpressure();
        logic [16:0] held_data;
        logic [1:0]  held_tag;
        int k;
        @(negedge clk);
        ab_in_valid = 1'b1;
        ab_in_data  = 31'h4000000;
        ab_in_tag   = 2'd2;
        @(negedge clk);
        ab_in_valid = 1'b0;
        k = 0;
        while (!a_out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        held_data = a_out_data;
        held_tag  = a_out_tag;
        checks++;
        if (held_data !== 17'h04000 || held_tag !== 2'd2) begin
            errors++;
            $display("FAIL bp_result: data=%0h tag=%0h required 4000 2", held_data, held_tag);
        end
        for (int i = 0; i < 10; i++) begin
            ab_in_valid = i[0];
            ab_in_data  = 31'h0123456 + 31'(i);
            ab_in_tag   = i[1:0];
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_data !== 17'h04000 || a_out_tag !== 2'd2) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b ready=%b data=%0h tag=%0h required 1 0 4000 2",
                         i, a_out_valid, a_in_ready, a_out_data, a_out_tag);
            end
        end
        ab_in_valid  = 1'b0;
        ab_out_ready = 1'b1;
        @(negedge clk);
        ab_out_ready = 1'b0;
        checks++;
        if ({a_in_ready, a_out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", a_in_ready, a_out_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({a_in_ready, a_out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_no_ghost: in_ready=%b out_valid=%b required 1 0", a_in_ready, a_out_valid);
        end
        $display("txn backpressure in=4000000 out=%0h tag=%0d", held_data, held_tag);
    endtask

    task automatic test_tags();
        ab_run("tag0", 31'h0900000, 2'd0, 17'h01800, 17'h01800, 0);
        ab_run("tag1", 31'h1000000, 2'd1, 17'h02000, 17'h02000, 1);
        ab_run("tag2", 31'h4000000, 2'd2, 17'h04000, 17'h04000, 0);
        ab_run("tag3", 31'h0000002, 2'd3, 17'h00002, 17'h00003, 3);
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        ab_in_valid = 1'b1;
        ab_in_data  = 31'h7FFFFFFF;
        ab_in_tag   = 2'd1;
        @(negedge clk);
        ab_in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({a_out_valid, a_out_data, a_in_ready, a_out_tag} !== 21'd0) begin
            errors++;
            $display("FAIL rst_mid_calc: valid=%b data=%0h ready=%b tag=%0h required all 0", a_out_valid, a_out_data, a_in_ready, a_out_tag);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ab_run("post_rst", 31'h0900000, 2'd2, 17'h01800, 17'h01800, 0);
    endtask

    task automatic test_bpc17();
        c_run("c_lsb2", 31'h0000002, 2'd1, 17'h00003);
        c_run("c_lsb6", 31'h0000006, 2'd2, 17'h00005);
        c_run("c_zero", 31'h0000000, 2'd3, 17'h00000);
        c_run("c_full", 31'h7FFFFFFF, 2'd0, 17'd92682);
    endtask

    task automatic test_back_to_back();
        int nr;
        int nv;
        nr = 0;
        nv = 0;
        @(negedge clk);
        c_in_valid  = 1'b1;
        c_in_data   = 31'h4000000;
        c_in_tag    = 2'd3;
        c_out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (c_in_ready) nr++;
            if (c_out_valid) begin
                nv++;
                checks++;
                if (c_out_data !== 17'h04000) begin
                    errors++;
                    $display("FAIL b2b_data: got %0h required 4000", c_out_data);
                end
            end
            @(negedge clk);
        end
        c_in_valid  = 1'b0;
        c_out_ready = 1'b0;
        checks++;
        if (nr != 4 || nv != 4) begin
            errors++;
            $display("FAIL b2b_rate: ready cycles=%0d valid cycles=%0d required 4 4", nr, nv);
        end
        $display("txn back_to_back samples=%0d ready_cycles=%0d", nv, nr);
    endtask

    task automatic test_saturate();
        d_run("d_one",      32'h01000000, 16'h1000);
        d_run("d_exact",    32'hFFFE0001, 16'hFFFF);
        d_run("d_roundup",  32'hFFFD0003, 16'hFFFF);
        d_run("d_below",    32'hFFFC0004, 16'hFFFE);
        d_run("d_saturate", 32'hFFFFFFFF, 16'hFFFF);
    endtask

    task automatic test_random();
        logic [30:0] x;
        longint unsigned r, q, rem, qr;
        for (int i = 0; i < 24; i++) begin
            x   = 31'($urandom) >> $urandom_range(0, 30);
            r   = longint'(x) << 2;
            q   = isqrt(r);
            rem = r - q * q;
            qr  = (rem > q) ? ((q == 64'h1FFFF) ? q : q + 1) : q;
            ab_run("rand", x, 2'(i), 17'(q), 17'(qr), $urandom_range(0, 3));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_tags();
        test_reset_mid_calc();
        test_bpc17();
        test_back_to_back();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
